// File: rtl/din_debouncer.sv
// Conditions one raw, bouncy level input into a clean, clock-synchronous level
// for the downstream DFF stage: two-flop synchronizer plus a stability-counting FSM.
module din_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int COUNT_W         = 8
) (
  input  logic               Clk,
  input  logic               SReset,
  input  logic               Din,
  input  logic               EdgeClr,
  output logic               Dout,
  output logic               RisePulse,
  output logic               FallPulse,
  output logic [COUNT_W-1:0] EdgeCount
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  state_t           state;
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Din is only ever seen through s1/s2 so the FSM never samples a metastable value.
  always_ff @(posedge Clk) begin
    if (SReset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= Din;
      s2 <= s1;
    end
  end

  always_ff @(posedge Clk) begin
    if (SReset) begin
      state     <= IDLE_LOW;
      cnt       <= '0;
      Dout      <= 1'b0;
      RisePulse <= 1'b0;
      FallPulse <= 1'b0;
      EdgeCount <= '0;
    end else begin
      RisePulse <= 1'b0;
      FallPulse <= 1'b0;
      if (EdgeClr) begin
        EdgeCount <= '0;
      end
      case (state)
        IDLE_LOW: begin
          if (s2) begin
            state <= WAIT_HIGH;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_HIGH: begin
          if (!s2) begin
            state <= IDLE_LOW;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state     <= IDLE_HIGH;
            cnt       <= '0;
            Dout      <= 1'b1;
            RisePulse <= 1'b1;
            // A clear landing on an accepted rise still counts that rise.
            EdgeCount <= EdgeClr ? COUNT_W'(1) : EdgeCount + COUNT_W'(1);
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        IDLE_HIGH: begin
          if (!s2) begin
            state <= WAIT_LOW;
            cnt   <= CNT_W'(1);
          end
        end
        WAIT_LOW: begin
          if (s2) begin
            state <= IDLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CntLast) begin
            state     <= IDLE_LOW;
            cnt       <= '0;
            Dout      <= 1'b0;
            FallPulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_din_debouncer.sv
// Directed bench for din_debouncer with DEBOUNCE_CYCLES=4 and a 2-bit EdgeCount
// so that wrap and clear behaviour are reachable in a short run.
module tb_din_debouncer;

  localparam int CW = 2;

  logic          Clk;
  logic          SReset;
  logic          Din;
  logic          EdgeClr;
  logic          Dout;
  logic          RisePulse;
  logic          FallPulse;
  logic [CW-1:0] EdgeCount;

  int errors = 0;
  int checks = 0;

  din_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16),
    .COUNT_W(CW)
  ) dut (
    .Clk(Clk),
    .SReset(SReset),
    .Din(Din),
    .EdgeClr(EdgeClr),
    .Dout(Dout),
    .RisePulse(RisePulse),
    .FallPulse(FallPulse),
    .EdgeCount(EdgeCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs are set, one rising edge passes, then outputs settle 1ns later.
  task automatic applyStimulus(input logic din, input logic clr, input logic rst);
    Din     = din;
    EdgeClr = clr;
    SReset  = rst;
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic dout, input logic rise,
                             input logic fall, input logic [CW-1:0] cnt);
    checks++;
    assert ({Dout, RisePulse, FallPulse, EdgeCount} === {dout, rise, fall, cnt})
    else begin
      errors++;
      $error("[TB] FAIL %s: got dout=%b rise=%b fall=%b cnt=%0d, expected dout=%b rise=%b fall=%b cnt=%0d",
             tag, Dout, RisePulse, FallPulse, EdgeCount, dout, rise, fall, cnt);
    end
  endtask

  task automatic holdCheck(input string tag, input logic din, input int n,
                           input logic dout, input logic [CW-1:0] cnt);
    for (int i = 0; i < n; i++) begin
      applyStimulus(din, 1'b0, 1'b0);
      checkOutput(tag, dout, 1'b0, 1'b0, cnt);
    end
  endtask

  // Din rises at edge E: quiet through E+4, accepted at E+5, pulse gone at E+6.
  task automatic riseSeq(input string tag, input logic [CW-1:0] prev,
                         input logic [CW-1:0] next, input logic clr);
    holdCheck({tag, "_wait"}, 1'b1, 5, 1'b0, prev);
    applyStimulus(1'b1, clr, 1'b0);
    checkOutput({tag, "_accept"}, 1'b1, 1'b1, 1'b0, next);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput({tag, "_after"}, 1'b1, 1'b0, 1'b0, next);
  endtask

  task automatic fallSeq(input string tag, input logic [CW-1:0] cnt);
    holdCheck({tag, "_wait"}, 1'b0, 5, 1'b1, cnt);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_accept"}, 1'b0, 1'b0, 1'b1, cnt);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_after"}, 1'b0, 1'b0, 1'b0, cnt);
  endtask

  initial begin
    Din     = 1'b0;
    EdgeClr = 1'b0;
    SReset  = 1'b1;
    $display("[TB] starting din_debouncer directed run");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      checkOutput("reset", 1'b0, 1'b0, 1'b0, 2'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("post_reset", 1'b0, 1'b0, 1'b0, 2'd0);
    holdCheck("idle_low", 1'b0, 3, 1'b0, 2'd0);

    riseSeq("clean_rise", 2'd0, 2'd1, 1'b0);
    fallSeq("clean_fall", 2'd1);

    // Three captured highs never reach the acceptance count.
    holdCheck("glitch3_high", 1'b1, 3, 1'b0, 2'd1);
    holdCheck("glitch3_low", 1'b0, 6, 1'b0, 2'd1);

    // Four captured highs are exactly enough; the low that follows then falls normally.
    holdCheck("glitch4_high", 1'b1, 4, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("glitch4_e4", 1'b0, 1'b0, 1'b0, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("glitch4_accept", 1'b1, 1'b1, 1'b0, 2'd2);
    holdCheck("glitch4_fallwait", 1'b0, 3, 1'b1, 2'd2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("glitch4_fall", 1'b0, 1'b0, 1'b1, 2'd2);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("glitch4_done", 1'b0, 1'b0, 1'b0, 2'd2);

    // Bounce 1,0,1,1,0 then settle high; only the final run is accepted.
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("bounce_0", 1'b0, 1'b0, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("bounce_1", 1'b0, 1'b0, 1'b0, 2'd2);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("bounce_2", 1'b0, 1'b0, 1'b0, 2'd2);
    applyStimulus(1'b1, 1'b0, 1'b0); checkOutput("bounce_3", 1'b0, 1'b0, 1'b0, 2'd2);
    applyStimulus(1'b0, 1'b0, 1'b0); checkOutput("bounce_4", 1'b0, 1'b0, 1'b0, 2'd2);
    riseSeq("bounce_rise", 2'd2, 2'd3, 1'b0);
    fallSeq("bounce_fall", 2'd3);

    riseSeq("wrap_rise", 2'd3, 2'd0, 1'b0);
    fallSeq("wrap_fall", 2'd0);
    riseSeq("count_rise1", 2'd0, 2'd1, 1'b0);
    fallSeq("count_fall1", 2'd1);
    riseSeq("count_rise2", 2'd1, 2'd2, 1'b0);
    fallSeq("count_fall2", 2'd2);

    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("clear_only", 1'b0, 1'b0, 1'b0, 2'd0);
    riseSeq("clear_rise", 2'd0, 2'd1, 1'b0);
    fallSeq("clear_fall", 2'd1);
    riseSeq("clear_on_accept", 2'd1, 2'd1, 1'b1);
    fallSeq("clear_on_accept_fall", 2'd1);

    // Reset lands while WAIT_HIGH holds cnt=2; the partial count must be thrown away.
    holdCheck("midreset_pre", 1'b1, 4, 1'b0, 2'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("midreset_reset", 1'b0, 1'b0, 1'b0, 2'd0);
    riseSeq("midreset_rise", 2'd0, 2'd1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
